// File: rtl/systolic_skew_feeder_pkg.sv
// rtl/systolic_skew_feeder_pkg.sv - shared state encodings for the systolic operand stages
package systolic_skew_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/skew_delay_line.sv
// rtl/skew_delay_line.sv - DEPTH-stage word shift register advancing on en; DEPTH=0 is a wire
module skew_delay_line #(
  parameter int DEPTH     = 0,
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WORD_SIZE-1:0] din,
  output logic [WORD_SIZE-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, clk, rst, en};
    assign dout = din;
  end else begin : g_chain
    logic [WORD_SIZE-1:0] chain [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) chain[i] <= '0;
      end else if (en) begin
        chain[0] <= din;
        for (int i = 1; i < DEPTH; i++) chain[i] <= chain[i-1];
      end
    end

    assign dout = chain[DEPTH-1];
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - diagonal-skew operand feeder with tile drain
// Optional SKEW_FEEDER_STATS_EN adds stall and tile counters.
module systolic_skew_feeder
  import systolic_skew_feeder_pkg::*;
#(
  parameter int ROWS      = 5,
  parameter int WORD_SIZE = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ROWS*WORD_SIZE-1:0] in_vec,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic [ROWS*WORD_SIZE-1:0] left_out_bus,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
`ifdef SKEW_FEEDER_STATS_EN
  output logic [31:0]               stat_stall_cycles,
  output logic [15:0]               stat_tiles,
`endif
  output logic                      tile_done
);

  localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;

  feeder_state_t             state, state_nx;
  logic [CW-1:0]             flush_cnt, flush_cnt_nx;
  logic                      out_ready_ok, accept, advance, last_beat;
  logic [ROWS*WORD_SIZE-1:0] taps;

  assign out_ready_ok = !out_valid || out_ready;
  assign in_ready     = out_ready_ok && (state != FLUSH);
  assign accept       = in_valid && in_ready;
  assign advance      = accept || ((state == FLUSH) && out_ready_ok);
  assign tile_done    = out_valid && out_ready && out_last;

  always_comb begin
    state_nx     = state;
    flush_cnt_nx = flush_cnt;
    last_beat    = 1'b0;
    case (state)
      IDLE, STREAM: begin
        if (accept) begin
          if (!in_last) begin
            state_nx = STREAM;
          end else if (ROWS == 1) begin
            // A single row has nothing to drain; the input beat closes the tile.
            state_nx  = IDLE;
            last_beat = 1'b1;
          end else begin
            state_nx     = FLUSH;
            flush_cnt_nx = CW'(ROWS - 1);
          end
        end
      end
      FLUSH: begin
        if (advance) begin
          flush_cnt_nx = flush_cnt - CW'(1);
          if (flush_cnt == CW'(1)) begin
            state_nx  = IDLE;
            last_beat = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Row r sees the word shifted in r advances ago; FLUSH shifts in zeros.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [WORD_SIZE-1:0] din;
    assign din = (state == FLUSH) ? '0 : in_vec[r*WORD_SIZE +: WORD_SIZE];

    skew_delay_line #(
      .DEPTH    (r),
      .WORD_SIZE(WORD_SIZE)
    ) u_delay (
      .clk (clk),
      .rst (rst),
      .en  (advance),
      .din (din),
      .dout(taps[r*WORD_SIZE +: WORD_SIZE])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      flush_cnt    <= '0;
      left_out_bus <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
    end else begin
      state     <= state_nx;
      flush_cnt <= flush_cnt_nx;
      if (advance) begin
        left_out_bus <= taps;
        out_valid    <= 1'b1;
        out_last     <= last_beat;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

`ifdef SKEW_FEEDER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_stall_cycles <= '0;
      stat_tiles        <= '0;
    end else begin
      if (out_valid && !out_ready && (stat_stall_cycles != '1))
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      if (tile_done && (stat_tiles != '1))
        stat_tiles <= stat_tiles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb/tb_systolic_skew_feeder.sv - directed bench for systolic_skew_feeder (ROWS=5 and ROWS=1)
module tb_systolic_skew_feeder;
  import systolic_skew_feeder_pkg::*;

  localparam int ROWS = 5;
  localparam int W    = 16;
  localparam int BW   = ROWS * W;

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] in_vec;
  logic          in_valid, in_last, in_ready;
  logic [BW-1:0] left_out_bus;
  logic          out_valid, out_ready, out_last, tile_done;

  logic [W-1:0]  r1_in_vec, r1_bus;
  logic          r1_in_valid, r1_in_last, r1_in_ready;
  logic          r1_out_valid, r1_out_last, r1_tile_done;
  logic          r1_flush_seen = 1'b0;

`ifdef SKEW_FEEDER_STATS_EN
  logic [31:0] stat_stall_cycles, r1_stat_stall_cycles;
  logic [15:0] stat_tiles, r1_stat_tiles;
`endif

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [BW-1:0] beats[$];
  logic          lasts[$];

  always #5 clk = ~clk;

  systolic_skew_feeder #(.ROWS(ROWS), .WORD_SIZE(W)) u_dut (
    .clk(clk), .rst(rst), .in_vec(in_vec), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .left_out_bus(left_out_bus),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
`ifdef SKEW_FEEDER_STATS_EN
    .stat_stall_cycles(stat_stall_cycles), .stat_tiles(stat_tiles),
`endif
    .tile_done(tile_done)
  );

  systolic_skew_feeder #(.ROWS(1), .WORD_SIZE(W)) u_dut1 (
    .clk(clk), .rst(rst), .in_vec(r1_in_vec), .in_valid(r1_in_valid),
    .in_last(r1_in_last), .in_ready(r1_in_ready), .left_out_bus(r1_bus),
    .out_valid(r1_out_valid), .out_ready(1'b1), .out_last(r1_out_last),
`ifdef SKEW_FEEDER_STATS_EN
    .stat_stall_cycles(r1_stat_stall_cycles), .stat_tiles(r1_stat_tiles),
`endif
    .tile_done(r1_tile_done)
  );

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      beats.push_back(left_out_bus);
      lasts.push_back(out_last);
    end
    if (tile_done) done_cnt++;
    if (u_dut1.state == FLUSH) r1_flush_seen = 1'b1;
  end

  function automatic logic [BW-1:0] mkvec(int k, logic [15:0] step, logic [15:0] off);
    logic [BW-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*W +: W] = 16'(int'(step) * k + int'(off) + r);
    return v;
  endfunction

  // Beat j, row r carries vector j-r row r while that vector exists, else zero.
  function automatic logic [BW-1:0] exp_beat(int j, input logic [BW-1:0] vecs[$]);
    logic [BW-1:0] b = '0;
    for (int r = 0; r < ROWS; r++)
      if (j - r >= 0 && j - r < vecs.size()) b[r*W +: W] = vecs[j-r][r*W +: W];
    return b;
  endfunction

  task automatic push(input logic [BW-1:0] v, input logic l, output int waits);
    logic acc;
    waits = 0;
    in_vec = v; in_valid = 1'b1; in_last = l;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) break;
      waits++;
      if (waits > 40) begin
        checks++; errors++;
        $display("FAIL push_timeout got no in_ready after %0d cycles, need accept", waits);
        break;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (tile_done) return;
    end
    checks++; errors++;
    $display("FAIL %s_done_timeout got no tile_done, need one within 80 cycles", name);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_vec = '0; out_ready = 1'b1;
    r1_in_valid = 1'b0; r1_in_last = 1'b0; r1_in_vec = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b need 0", out_valid); end
    checks++; if (left_out_bus !== '0) begin errors++; $display("FAIL reset_bus got %h need 0", left_out_bus); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b need 0", out_last); end
    checks++; if (tile_done !== 1'b0) begin errors++; $display("FAIL reset_tile_done got %b need 0", tile_done); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b need 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic_tile();
    logic [BW-1:0] vecs[$];
    int d0 = done_cnt, w;
    beats.delete(); lasts.delete();
    for (int k = 0; k < 3; k++) vecs.push_back(mkvec(k, 16'h0010, 16'h0000));
    for (int k = 0; k < 3; k++) push(vecs[k], k == 2, w);
    wait_done("basic");
    @(posedge clk); #1; repeat (2) @(posedge clk); #1;
    checks++; if (beats.size() != 7) begin errors++; $display("FAIL basic_beat_count got %0d need 7", beats.size()); end
    if (beats.size() == 7) begin
      for (int j = 0; j < 7; j++) begin
        checks++; if (beats[j] !== exp_beat(j, vecs)) begin errors++; $display("FAIL basic_beat%0d got %h need %h", j, beats[j], exp_beat(j, vecs)); end
        checks++; if (lasts[j] !== (j == 6)) begin errors++; $display("FAIL basic_last%0d got %b need %b", j, lasts[j], j == 6); end
      end
      checks++; if (beats[0] !== '0) begin errors++; $display("FAIL basic_hand_beat0 got %h need 0", beats[0]); end
      checks++; if (beats[2] !== {16'h0000, 16'h0000, 16'h0002, 16'h0011, 16'h0020}) begin errors++; $display("FAIL basic_hand_beat2 got %h", beats[2]); end
      checks++; if (beats[6] !== {16'h0024, 64'h0}) begin errors++; $display("FAIL basic_hand_beat6 got %h", beats[6]); end
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_tile_done got %0d pulses need 1", done_cnt - d0); end
  endtask

  task automatic test_gap();
    logic [BW-1:0] vecs[$];
    int w;
    beats.delete(); lasts.delete();
    for (int k = 0; k < 3; k++) vecs.push_back(mkvec(k, 16'h0010, 16'h0000));
    push(vecs[0], 1'b0, w);
    push(vecs[1], 1'b0, w);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gap_pre_valid got %b need 1", out_valid); end
    for (int g = 0; g < 2; g++) begin
      @(posedge clk); #1; @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL gap_valid%0d got %b need 0", g, out_valid); end
    end
    @(posedge clk); #1;
    push(vecs[2], 1'b1, w);
    wait_done("gap");
    @(posedge clk); #1; repeat (2) @(posedge clk); #1;
    checks++; if (beats.size() != 7) begin errors++; $display("FAIL gap_beat_count got %0d need 7", beats.size()); end
    if (beats.size() == 7)
      for (int j = 0; j < 7; j++) begin
        checks++; if (beats[j] !== exp_beat(j, vecs)) begin errors++; $display("FAIL gap_beat%0d got %h need %h", j, beats[j], exp_beat(j, vecs)); end
      end
  endtask

  task automatic test_flush_stall();
    logic [BW-1:0] vecs[$];
    logic [BW-1:0] snap;
    int w;
    beats.delete(); lasts.delete();
    for (int k = 0; k < 3; k++) vecs.push_back(mkvec(k, 16'h0100, 16'h0300));
    for (int k = 0; k < 3; k++) push(vecs[k], k == 2, w);
    @(posedge clk); #1;
    out_ready = 1'b0;
    snap = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) snap = left_out_bus;
      checks++; if (left_out_bus !== snap) begin errors++; $display("FAIL stall_bus%0d got %h need %h", i, left_out_bus, snap); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid%0d got %b need 1", i, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready%0d got %b need 0", i, in_ready); end
    end
    checks++; if (snap !== exp_beat(3, vecs)) begin errors++; $display("FAIL stall_held_beat got %h need %h", snap, exp_beat(3, vecs)); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done("stall");
    @(posedge clk); #1; repeat (2) @(posedge clk); #1;
    checks++; if (beats.size() != 7) begin errors++; $display("FAIL stall_beat_count got %0d need 7", beats.size()); end
    if (beats.size() == 7)
      for (int j = 0; j < 7; j++) begin
        checks++; if (beats[j] !== exp_beat(j, vecs)) begin errors++; $display("FAIL stall_beat%0d got %h need %h", j, beats[j], exp_beat(j, vecs)); end
      end
`ifdef SKEW_FEEDER_STATS_EN
    checks++; if (stat_stall_cycles !== 32'd3) begin errors++; $display("FAIL stat_stall got %0d need 3", stat_stall_cycles); end
    checks++; if (stat_tiles !== 16'd3) begin errors++; $display("FAIL stat_tiles got %0d need 3", stat_tiles); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] va[$];
    logic [BW-1:0] vb[$];
    int d0 = done_cnt, w;
    beats.delete(); lasts.delete();
    va.push_back(mkvec(1, 16'h0100, 16'h0A00));
    vb.push_back(mkvec(2, 16'h0100, 16'h0A00));
    push(va[0], 1'b1, w);
    wait_done("b2b_first");
    @(posedge clk); #1;
    push(vb[0], 1'b1, w);
    checks++; if (w != 0) begin errors++; $display("FAIL b2b_accept_delay got %0d cycles need 0", w); end
    wait_done("b2b_second");
    @(posedge clk); #1; repeat (2) @(posedge clk); #1;
    checks++; if (beats.size() != 10) begin errors++; $display("FAIL b2b_beat_count got %0d need 10", beats.size()); end
    if (beats.size() == 10)
      for (int j = 0; j < 10; j++) begin
        checks++;
        if (beats[j] !== ((j < 5) ? exp_beat(j, va) : exp_beat(j - 5, vb))) begin
          errors++; $display("FAIL b2b_beat%0d got %h", j, beats[j]);
        end
        checks++; if (lasts[j] !== (j == 4 || j == 9)) begin errors++; $display("FAIL b2b_last%0d got %b", j, lasts[j]); end
      end
    checks++; if (done_cnt - d0 != 2) begin errors++; $display("FAIL b2b_tile_done got %0d pulses need 2", done_cnt - d0); end
  endtask

  task automatic test_reset_mid_tile();
    logic [BW-1:0] vecs[$];
    logic [BW-1:0] fresh[$];
    int d0 = done_cnt, w;
    for (int k = 0; k < 3; k++) vecs.push_back(mkvec(k, 16'h0010, 16'h0500));
    for (int k = 0; k < 3; k++) push(vecs[k], k == 2, w);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b need 0", out_valid); end
    checks++; if (left_out_bus !== '0) begin errors++; $display("FAIL rstmid_bus got %h need 0", left_out_bus); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rstmid_last got %b need 0", out_last); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b need 1", in_ready); end
    checks++; if (u_dut.state !== IDLE) begin errors++; $display("FAIL rstmid_state got %0d need IDLE", u_dut.state); end
    repeat (3) @(negedge clk);
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL rstmid_no_done got %0d pulses need 0", done_cnt - d0); end
    @(posedge clk); #1;
    beats.delete(); lasts.delete();
    for (int k = 0; k < 2; k++) fresh.push_back(mkvec(k + 1, 16'h1000, 16'h00C0));
    for (int k = 0; k < 2; k++) push(fresh[k], k == 1, w);
    wait_done("rstmid_fresh");
    @(posedge clk); #1; repeat (2) @(posedge clk); #1;
    checks++; if (beats.size() != 6) begin errors++; $display("FAIL rstmid_beat_count got %0d need 6", beats.size()); end
    if (beats.size() == 6)
      for (int j = 0; j < 6; j++) begin
        checks++; if (beats[j] !== exp_beat(j, fresh)) begin errors++; $display("FAIL rstmid_beat%0d got %h need %h", j, beats[j], exp_beat(j, fresh)); end
      end
  endtask

  task automatic test_rows1();
    r1_in_vec = 16'h1111; r1_in_valid = 1'b1; r1_in_last = 1'b0;
    @(negedge clk);
    checks++; if (r1_in_ready !== 1'b1) begin errors++; $display("FAIL r1_in_ready got %b need 1", r1_in_ready); end
    @(posedge clk); #1;
    r1_in_vec = 16'h2222; r1_in_last = 1'b1;
    @(negedge clk);
    checks++; if (r1_out_valid !== 1'b1 || r1_bus !== 16'h1111) begin errors++; $display("FAIL r1_beat0 got v=%b %h need v=1 1111", r1_out_valid, r1_bus); end
    checks++; if (r1_out_last !== 1'b0) begin errors++; $display("FAIL r1_last0 got %b need 0", r1_out_last); end
    @(posedge clk); #1;
    r1_in_valid = 1'b0; r1_in_last = 1'b0;
    @(negedge clk);
    checks++; if (r1_out_valid !== 1'b1 || r1_bus !== 16'h2222) begin errors++; $display("FAIL r1_beat1 got v=%b %h need v=1 2222", r1_out_valid, r1_bus); end
    checks++; if (r1_out_last !== 1'b1 || r1_tile_done !== 1'b1) begin errors++; $display("FAIL r1_last1 got last=%b done=%b need 1 1", r1_out_last, r1_tile_done); end
    checks++; if (u_dut1.state !== IDLE) begin errors++; $display("FAIL r1_state got %0d need IDLE", u_dut1.state); end
    @(posedge clk); #1; @(negedge clk);
    checks++; if (r1_out_valid !== 1'b0) begin errors++; $display("FAIL r1_drained got %b need 0", r1_out_valid); end
    checks++; if (r1_flush_seen !== 1'b0) begin errors++; $display("FAIL r1_flush_seen got %b need 0", r1_flush_seen); end
  endtask

  initial begin
    test_reset();
    test_basic_tile();
    test_gap();
    test_flush_stall();
    test_back_to_back();
    test_reset_mid_tile();
    test_rows1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
